// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared types for the RSA datapath control blocks. Holds the
//                compare FSM state encoding, the digit compare result
//                encoding and a helper that validates operand/digit widths.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package rsa_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CMP_GT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_LT = 2'd2
  } cmp_res_t;

  // An operand has to split into a whole, non-zero number of digits.
  function automatic bit digit_split_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/comp_digit.sv
`default_nettype none
// ============================================================================
//  Module      : comp_digit
//  Description : Combinational DIGIT-bit magnitude compare. With flip_msb set
//                the MSB of both digits is inverted first, which turns an
//                unsigned compare into a two's-complement compare of the
//                most significant digit.
//  Ports       : a, b      digits to compare
//                flip_msb  invert MSB of both digits before comparing
//                g         a > b (after optional flip)
//                e         a == b
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module comp_digit #(
  parameter int DIGIT = 32
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             flip_msb,
  output logic             g,
  output logic             e
);

  logic [DIGIT-1:0] w_mask;
  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;

  always_comb begin
    w_mask            = '0;
    w_mask[DIGIT-1]   = flip_msb;
  end

  assign w_a = a ^ w_mask;
  assign w_b = b ^ w_mask;
  assign g   = (w_a > w_b);
  assign e   = (w_a == w_b);

endmodule
`default_nettype wire

// File: rtl/bigcomp_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bigcomp_serial
//  Description : Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per
//                cycle, most significant digit first, stopping at the first
//                differing digit. Unsigned or two's-complement mode.
//  Ports       : clk, rst         clock, async active-high reset
//                start            request, taken only while idle
//                ina, inb, mode   operands and mode (1 = signed), latched
//                                 at the accepted start edge
//                busy             compare in progress
//                done             one-cycle result-valid pulse
//                gt, eq, lt       registered result flags
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module bigcomp_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] c_last = IW'(NDIG - 1);

  generate
    if (!digit_split_ok(WIDTH, DIGIT)) begin : g_bad_split
      $error("bigcomp_serial: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic             r_mode, w_mode_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_gt, w_gt_nxt;
  logic             r_eq, w_eq_nxt;
  logic             r_lt, w_lt_nxt;

  logic             w_flip;
  logic             w_dig_g;
  logic             w_dig_e;
  cmp_res_t         w_res;

  // Operand registers shift left one digit per scanned digit, so the digit
  // under test is always the top DIGIT bits; only the top digit carries the
  // sign and gets its MSB flipped in signed mode.
  assign w_flip = r_mode && (r_idx == c_last);

  comp_digit #(
    .DIGIT    (DIGIT)
  ) u_digit (
    .a        (r_a[WIDTH-1 -: DIGIT]),
    .b        (r_b[WIDTH-1 -: DIGIT]),
    .flip_msb (w_flip),
    .g        (w_dig_g),
    .e        (w_dig_e)
  );

  always_comb begin
    if (w_dig_e)      w_res = CMP_EQ;
    else if (w_dig_g) w_res = CMP_GT;
    else              w_res = CMP_LT;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_mode_nxt  = r_mode;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_gt_nxt    = r_gt;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_a_nxt     = ina;
          w_b_nxt     = inb;
          w_mode_nxt  = mode;
          w_idx_nxt   = c_last;
          w_gt_nxt    = 1'b0;
          w_eq_nxt    = 1'b0;
          w_lt_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_res != CMP_EQ) begin
          w_gt_nxt    = (w_res == CMP_GT);
          w_lt_nxt    = (w_res == CMP_LT);
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_idx == '0) begin
          w_eq_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt   = r_idx - IW'(1);
          w_a_nxt     = r_a << DIGIT;
          w_b_nxt     = r_b << DIGIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_mode  <= w_mode_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_gt    <= w_gt_nxt;
      r_eq    <= w_eq_nxt;
      r_lt    <= w_lt_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_bigcomp_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bigcomp_serial
//  Description : Self-checking bench for bigcomp_serial. Three instances
//                (64/8, 1024/32, 1024/1024) share clock, reset and operand
//                buses; each has its own start. Results and latency are
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bigcomp_serial;

  logic          clk;
  logic          rst;
  logic [1023:0] ina;
  logic [1023:0] inb;
  logic          mode;
  logic [2:0]    start_v;
  logic [2:0]    busy_v, done_v, gt_v, eq_v, lt_v;

  int sel;
  int n_checks;
  int n_errors;

  logic busy_s, done_s;
  logic [2:0] flags_s;

  assign busy_s  = busy_v[sel];
  assign done_s  = done_v[sel];
  assign flags_s = {gt_v[sel], eq_v[sel], lt_v[sel]};

  bigcomp_serial #(.WIDTH(64), .DIGIT(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .ina(ina[63:0]), .inb(inb[63:0]),
    .mode(mode), .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0])
  );

  bigcomp_serial #(.WIDTH(1024), .DIGIT(32)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .ina(ina), .inb(inb),
    .mode(mode), .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1])
  );

  bigcomp_serial #(.WIDTH(1024), .DIGIT(1024)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .ina(ina), .inb(inb),
    .mode(mode), .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 64 : 1024;
  endfunction

  function automatic int digit_of(input int s);
    return (s == 0) ? 8 : ((s == 1) ? 32 : 1024);
  endfunction

  function automatic logic [1023:0] low_mask(input int w);
    logic [1023:0] one;
    one = 1024'(1);
    return (w >= 1024) ? '1 : ((one << w) - one);
  endfunction

  // Expected {gt,eq,lt}: operands interpreted as plain integers.
  function automatic logic [2:0] ref_cmp(input logic [1023:0] a, input logic [1023:0] b,
                                         input logic m, input int w);
    logic signed [1025:0] va, vb, one;
    logic [1023:0] am, bm;
    one = 1026'sd1;
    am  = a & low_mask(w);
    bm  = b & low_mask(w);
    va  = $signed({2'b00, am});
    vb  = $signed({2'b00, bm});
    if (m && am[w-1]) va = va - (one <<< w);
    if (m && bm[w-1]) vb = vb - (one <<< w);
    return {va > vb, va == vb, va < vb};
  endfunction

  // Digits examined: from the top digit down to the highest differing one.
  function automatic int ref_lat(input logic [1023:0] a, input logic [1023:0] b,
                                 input int w, input int d);
    logic [1023:0] x;
    int hb;
    x  = (a ^ b) & low_mask(w);
    hb = -1;
    for (int i = 0; i < w; i++) if (x[i]) hb = i;
    if (hb < 0) return w / d;
    return (w / d) - (hb / d);
  endfunction

  // Start a compare on instance s and wait for done (bounded).
  task automatic run_cmp(input int s, input logic [1023:0] a, input logic [1023:0] b,
                         input logic m, output logic [2:0] res, output int lat,
                         output int bcnt);
    @(negedge clk);
    sel     = s;
    ina     = a;
    inb     = b;
    mode    = m;
    start_v = 3'b001 << s;
    @(posedge clk);
    #1;
    start_v = '0;
    check("flags_clear", {61'd0, flags_s}, 64'd0);
    lat  = 0;
    bcnt = 0;
    while (!done_s && lat < 40) begin
      if (busy_s) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = flags_s;
  endtask

  task automatic cmp_and_check(input string tag, input int s, input logic [1023:0] a,
                               input logic [1023:0] b, input logic m);
    logic [2:0] res;
    int lat, bcnt, k;
    run_cmp(s, a, b, m, res, lat, bcnt);
    k = ref_lat(a, b, width_of(s), digit_of(s));
    check({tag, "_res"}, {61'd0, res}, {61'd0, ref_cmp(a, b, m, width_of(s))});
    check({tag, "_lat"}, 64'(lat), 64'(k));
    check({tag, "_busy"}, 64'(bcnt), 64'(k));
  endtask

  task automatic rand_op(input int w, output logic [1023:0] a, output logic [1023:0] b);
    logic [1023:0] r, lm;
    int p;
    for (int i = 0; i < 32; i++) begin
      a[i*32 +: 32] = $urandom();
      r[i*32 +: 32] = $urandom();
    end
    p  = $urandom_range(0, w);
    lm = low_mask(p);
    b  = (a & ~lm) | (r & lm);
  endtask

  initial begin
    logic [1023:0] a, b;
    logic [2:0] res;
    int lat, bcnt, seen;

    n_checks = 0;
    n_errors = 0;
    sel      = 0;
    rst      = 1'b1;
    start_v  = '0;
    ina      = '0;
    inb      = '0;
    mode     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {49'd0, busy_v, done_v, gt_v, eq_v, lt_v}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases on the 64/8 instance
    cmp_and_check("eq_unsigned", 0, 1024'h1, 1024'h1, 1'b0);
    cmp_and_check("top_unsigned", 0, 1024'h8000_0000_0000_0000, 1024'h1, 1'b0);
    cmp_and_check("top_signed", 0, 1024'h8000_0000_0000_0000, 1024'h1, 1'b1);
    cmp_and_check("neg1_vs_neg2", 0, 1024'hFFFF_FFFF_FFFF_FFFF, 1024'hFFFF_FFFF_FFFF_FFFE, 1'b1);

    // start while busy must be ignored
    @(negedge clk);
    sel = 0; ina = 1024'h5; inb = 1024'h5; mode = 1'b0; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = '0;
    @(posedge clk); #1;
    ina = 1024'h9; inb = 1024'h1; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = '0;
    lat = 2;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_res", {61'd0, flags_s}, 64'b010);
    check("ignore_lat", 64'(lat), 64'd8);

    // back-to-back: start in the done cycle
    @(negedge clk);
    ina = 1024'h1; inb = 1024'h1; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = '0;
    lat = 0;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first", {61'd0, flags_s}, 64'b010);
    ina = 1024'h2; inb = 1024'h4; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = '0;
    check("b2b_busy", {63'd0, busy_s}, 64'd1);
    lat = 0;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_res", {61'd0, flags_s}, 64'b001);
    check("b2b_lat", 64'(lat), 64'd8);

    // reset in the middle of a compare
    @(negedge clk);
    ina = 1024'h0; inb = 1024'h0; start_v = 3'b001;
    @(posedge clk); #1;
    start_v = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_outs", {49'd0, busy_v, done_v, gt_v, eq_v, lt_v}, 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_v != 3'b000 || busy_v != 3'b000) seen++;
    end
    check("midrst_quiet", 64'(seen), 64'd0);
    cmp_and_check("after_rst", 0, 1024'h3, 1024'h3, 1'b0);

    // Randomised sweep
    for (int s = 0; s < 3; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < ((s == 0) ? 100 : 500); n++) begin
          rand_op(width_of(s), a, b);
          cmp_and_check("rand", s, a, b, m[0]);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
